// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared types and constants for the Goldschmidt divider controller.
//   state_t  - controller state encoding
//   OP_*     - fdiv operation select codes
//   RM_*     - fdiv multiplier-operand mux select codes
//   ctl_t    - bundle of all controller outputs
//   decode() - Moore output decode of a state
package fdiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT_A = 3'd1,
        S_INIT_B = 3'd2,
        S_ITER_A = 3'd3,
        S_ITER_B = 3'd4,
        S_ROUND  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [1:0] OP_INIT  = 2'b00;
    localparam logic [1:0] OP_ITER  = 2'b01;
    localparam logic [1:0] OP_ROUND = 2'b10;

    localparam logic [1:0] RM_INIT = 2'b00;
    localparam logic [1:0] RM_SEED = 2'b01;
    localparam logic [1:0] RM_ITA  = 2'b10;
    localparam logic [1:0] RM_ITB  = 2'b11;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] rm;
        logic       ena;
        logic       enb;
        logic       enc;
        logic       busy;
        logic       done;
    } ctl_t;

    // ena and enb/enc are never set together, and no enable accompanies OP_ROUND.
    function automatic ctl_t decode(state_t s);
        ctl_t c;
        c = '0;
        c.busy = (s != S_IDLE);
        case (s)
            S_INIT_A: begin c.op = OP_INIT;  c.rm = RM_INIT; c.ena = 1'b1; end
            S_INIT_B: begin c.op = OP_INIT;  c.rm = RM_SEED; c.enb = 1'b1; c.enc = 1'b1; end
            S_ITER_A: begin c.op = OP_ITER;  c.rm = RM_ITA;  c.ena = 1'b1; end
            S_ITER_B: begin c.op = OP_ITER;  c.rm = RM_ITB;  c.enb = 1'b1; c.enc = 1'b1; end
            S_ROUND:  begin c.op = OP_ROUND; c.rm = RM_SEED; end
            S_DONE:   begin c.op = OP_ROUND; c.rm = RM_SEED; c.done = 1'b1; end
            default:  ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fdiv_iter_cnt.sv
// fdiv_iter_cnt: Goldschmidt refinement iteration counter.
//   clk, reset - clock, async active-high reset
//   clr        - clear count to zero
//   inc        - count one completed ITER_A/ITER_B pair
//   tc         - high when the pair being finished is the last one (cnt == NITER-1)
//   cnt        - current completed-pair count
module fdiv_iter_cnt #(
    parameter int NITER = 5,
    parameter int W     = $clog2(NITER + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic         tc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + W'(1);
    end

    // Looked at while in ITER_B: this exit brings the count up to NITER.
    assign tc = (cnt == W'(NITER - 1));

endmodule

// File: rtl/fdiv_ctrl.sv
// fdiv_ctrl: sequencing FSM for the Goldschmidt fdiv datapath (instantiated
// beside this block at top level; no arithmetic here).
//   clk, reset      - clock, async active-high reset
//   start           - begin a divide (sampled only in IDLE)
//   abort           - synchronous cancel of an in-flight divide
//   op, rm          - fdiv operation select / multiplier-operand mux select
//   ena, enb, enc   - fdiv register-bank load enables
//   busy            - high in every state but IDLE
//   done            - one-cycle pulse, fdiv Q valid
module fdiv_ctrl
    import fdiv_pkg::*;
#(
    parameter int NITER = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic [1:0] op,
    output logic [1:0] rm,
    output logic       ena,
    output logic       enb,
    output logic       enc,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(NITER + 1);

    state_t        state, nxt;
    ctl_t          ctl_q;
    logic          cnt_clr, cnt_inc, cnt_tc;
    logic [CW-1:0] cnt;

    assign cnt_clr = (state == S_IDLE) && start;
    assign cnt_inc = (state == S_ITER_B) && !abort;

    fdiv_iter_cnt #(.NITER(NITER), .W(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (cnt_tc),
        .cnt   (cnt)
    );

    // Abort only matters outside IDLE, so start always wins in IDLE.
    always_comb begin
        nxt = state;
        if (state == S_IDLE) begin
            if (start) nxt = S_INIT_A;
        end else if (abort) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_INIT_A: nxt = S_INIT_B;
                S_INIT_B: nxt = S_ITER_A;
                S_ITER_A: nxt = S_ITER_B;
                S_ITER_B: nxt = cnt_tc ? S_ROUND : S_ITER_A;
                S_ROUND:  nxt = S_DONE;
                default:  nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the decode of the next state, so they are
    // glitch-free yet still exactly the Moore decode of the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            ctl_q <= '0;
        end else begin
            state <= nxt;
            ctl_q <= decode(nxt);
        end
    end

    assign op   = ctl_q.op;
    assign rm   = ctl_q.rm;
    assign ena  = ctl_q.ena;
    assign enb  = ctl_q.enb;
    assign enc  = ctl_q.enc;
    assign busy = ctl_q.busy;
    assign done = ctl_q.done;

endmodule

// File: doc/fdiv_ctrl.md
FDIV_CTRL -- requirements
Module: fdiv_ctrl

Interface
REQ-001 The block SHALL have parameter NITER, default 5, meaning the number of Goldschmidt refinement iterations (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, requesting a divide; it is sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit, a synchronous cancel of an in-flight divide.
REQ-006 The block SHALL have port op, output, 2 bits, the fdiv operation select: 00 init, 01 iterate, 10 round.
REQ-007 The block SHALL have port rm, output, 2 bits, the fdiv multiplier-operand mux select.
REQ-008 The block SHALL have ports ena, enb and enc, outputs, 1 bit each, the fdiv register-bank load enables.
REQ-009 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking that fdiv Q is valid.

Function
REQ-011 The states SHALL be IDLE, INIT_A, INIT_B, ITER_A, ITER_B, ROUND and DONE, with all outputs a Moore decode of the state register.
REQ-012 Outputs per state SHALL be as follows:
- IDLE: op=00, rm=00, ena=enb=enc=0.
- INIT_A: op=00, rm=00, ena=1.
- INIT_B: op=00, rm=01, enb=enc=1.
- ITER_A: op=01, rm=10, ena=1.
- ITER_B: op=01, rm=11, enb=enc=1.
- ROUND: op=10, rm=01, all enables 0.
- DONE: op=10, rm=01, all enables 0, done=1.
REQ-013 Transitions SHALL be as follows:
- IDLE->INIT_A when start=1.
- INIT_A->INIT_B->ITER_A unconditionally.
- ITER_A->ITER_B unconditionally.
- ITER_B->ITER_A while iteration count < NITER, else ITER_B->ROUND.
- ROUND->DONE->IDLE unconditionally.
REQ-014 The iteration counter SHALL clear on entering INIT_A and increment on each ITER_B exit; its width SHALL be $clog2(NITER+1).
REQ-015 Latency from the start-sampling edge to the done pulse SHALL be 2+2*NITER+2 cycles (14 for NITER=5).
REQ-016 start SHALL be ignored while busy=1; no queuing.
REQ-017 start asserted in the same cycle DONE is left SHALL NOT be accepted; it is accepted only in the following IDLE cycle.
REQ-018 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no done pulse; abort in IDLE SHALL have no effect.
REQ-019 If abort and start are both high in IDLE, start SHALL win.
REQ-020 Enables SHALL never be asserted in the same cycle as op=10, and ena SHALL never be asserted together with enb or enc.

Reset
REQ-021 Asserting reset SHALL immediately force IDLE, clear the counter, and drive op=00, rm=00, ena=enb=enc=0, busy=0 and done=0.
REQ-022 Reset asserted mid-divide SHALL discard the operation with no done pulse; operation resumes from IDLE on the first clock edge after deassertion.

Structure
REQ-023 Package fdiv_pkg SHALL hold:
- the state enum;
- op constants OP_INIT=2'b00, OP_ITER=2'b01, OP_ROUND=2'b10;
- rm constants RM_INIT=2'b00, RM_SEED=2'b01, RM_ITA=2'b10, RM_ITB=2'b11.
REQ-024 The iteration counter SHALL be a sub-module named fdiv_iter_cnt with clear, inc and terminal-count ports.
REQ-025 fdiv_ctrl SHALL contain no datapath arithmetic; fdiv is instantiated beside it at top level.

Verification
REQ-026 Nominal divide: reset, then start for 1 cycle with fdiv N=0x3FB851EC (1.44) and D=0x3FA147AE (1.26) -> done exactly 14 cycles later, and Q=0x3F924925 within ±1 ulp.
REQ-027 Sequence trace: with NITER=5, check for exactly 5 ITER_A/ITER_B pairs; check that ena and enb|enc alternate every cycle from INIT_A through the last ITER_B; check busy is high for 14 cycles.
REQ-028 Start while busy: start pulsed at cycles 3 and 9 of a divide -> exactly one done pulse and no restart.
REQ-029 Abort: abort at cycle 6 (ITER_B) -> IDLE next cycle, all outputs zero, no done; a following start produces a normal divide with correct Q.
REQ-030 Async reset mid-ROUND: reset asserted between clock edges -> outputs zero before the next edge, no done; back-to-back divides after release both complete in 14 cycles.
REQ-031 Parameter sweep: NITER=1 -> latency 6 cycles; NITER=15 -> latency 34 cycles, with counter terminal count correct.
